// File: rtl/nios_ledr_sequencer.sv
// Autonomous LED pattern sequencer: an Avalon-MM slave holds mode/pattern/period,
// and an Avalon-MM master writes each step into the 16-bit LED PIO register 0.
module nios_ledr_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_COUNT  = 2'd3;

  state_t      state;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] pattern;
  logic [23:0] period;
  logic [15:0] cur;
  logic        phase;
  logic [23:0] cnt;

  logic        wr_en;
  logic        ctrl_wr;
  logic        force_wr;
  logic        running;
  logic [23:0] period_m1;
  logic [15:0] adv_cur;
  logic        adv_phase;
  logic        unused_wdata;

  assign wr_en     = chipselect && !write_n;
  assign ctrl_wr   = wr_en && (address == 2'd0);
  assign force_wr  = wr_en && (address == 2'd3) && writedata[0];
  assign running   = (state != IDLE);
  // A zero period behaves like a period of one cycle.
  assign period_m1 = (period == 24'd0) ? 24'd0 : period - 24'd1;
  assign m_address = 2'b00;
  assign unused_wdata = &{1'b0, writedata[31:24]};

  always_comb begin
    adv_cur   = cur;
    adv_phase = phase;
    case (mode)
      MODE_STATIC: adv_cur = pattern;
      MODE_ROTATE: adv_cur = {cur[14:0], cur[15]};
      MODE_BLINK: begin
        adv_phase = ~phase;
        adv_cur   = adv_phase ? pattern : 16'h0000;
      end
      MODE_COUNT:  adv_cur = cur + 16'd1;
      default:     adv_cur = cur;
    endcase
  end

  always_comb begin
    readdata = 32'h0;
    case (address)
      2'd0:    readdata = {29'b0, mode, enable};
      2'd1:    readdata = {16'b0, pattern};
      2'd2:    readdata = {8'b0, period};
      2'd3:    readdata = {cur, 15'b0, running};
      default: readdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      enable       <= 1'b0;
      mode         <= 2'd0;
      pattern      <= 16'h0;
      period       <= 24'h0;
      cur          <= 16'h0;
      phase        <= 1'b0;
      cnt          <= 24'h0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= 32'h0;
    end else begin
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;

      if (wr_en) begin
        case (address)
          2'd0:    {mode, enable} <= writedata[2:0];
          2'd1:    pattern <= writedata[15:0];
          2'd2:    period  <= writedata[23:0];
          default: ;
        endcase
      end

      // Disable wins over everything, including a strobe due from WRITE.
      if (ctrl_wr && !writedata[0]) begin
        state <= IDLE;
      end else begin
        if (state == WRITE) begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_writedata  <= {16'b0, cur};
        end
        if (ctrl_wr) begin
          cur   <= pattern;
          phase <= 1'b1;
          state <= WRITE;
        end else begin
          case (state)
            WRITE: begin
              cnt   <= period_m1;
              state <= COUNT;
            end
            COUNT: begin
              if ((cnt == 24'd0) || force_wr) begin
                cur   <= adv_cur;
                phase <= adv_phase;
                state <= WRITE;
              end else begin
                cnt <= cnt - 24'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_ledr_sequencer.sv
// Directed bench for nios_ledr_sequencer: static, rotate, count, blink, force,
// disable and asynchronous reset scenarios with hand-computed LED data.
module tb_nios_ledr_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;

  int checks;
  int failures;

  nios_ledr_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single slave write: driven at a negedge, sampled on the next posedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    chk(tag, readdata, exp);
    address = 2'd0;
  endtask

  task automatic idle_chk(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_quiet"}, {31'b0, m_chipselect}, 32'd0);
    end
  endtask

  // Expect gap-1 quiet cycles, then one strobe carrying data.
  task automatic expect_strobe(input int gap, input logic [15:0] data, input string tag);
    idle_chk(gap - 1, tag);
    @(negedge clk);
    chk({tag, "_cs"}, {31'b0, m_chipselect}, 32'd1);
    chk({tag, "_wn"}, {31'b0, m_write_n}, 32'd0);
    chk({tag, "_data"}, m_writedata, {16'b0, data});
    chk({tag, "_addr"}, {30'b0, m_address}, 32'd0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cs", {31'b0, m_chipselect}, 32'd0);
    chk("rst_wn", {31'b0, m_write_n}, 32'd1);
    chk("rst_wd", m_writedata, 32'h0);
    chk("rst_addr", {30'b0, m_address}, 32'd0);
    for (int a = 0; a < 4; a++) rd_chk(a[1:0], 32'h0, "rst_rd");
    reset_n = 1'b1;
    @(negedge clk);

    // Static mode, period 3: strobes every 4 cycles
    wr(2'd1, 32'h0000_00F0);
    wr(2'd2, 32'd3);
    rd_chk(2'd1, 32'h0000_00F0, "rd_pattern");
    rd_chk(2'd2, 32'h0000_0003, "rd_period");
    wr(2'd0, 32'h1);
    expect_strobe(1, 16'h00F0, "st0");
    rd_chk(2'd3, 32'h00F0_0001, "st_status");
    rd_chk(2'd0, 32'h0000_0001, "st_ctrl");
    expect_strobe(4, 16'h00F0, "st1");
    expect_strobe(4, 16'h00F0, "st2");

    // Rotate mode, period 1
    wr(2'd0, 32'h0);
    idle_chk(2, "dis1");
    wr(2'd1, 32'h0000_8001);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h3);
    expect_strobe(1, 16'h8001, "rot0");
    expect_strobe(2, 16'h0003, "rot1");
    expect_strobe(2, 16'h0006, "rot2");
    expect_strobe(2, 16'h000C, "rot3");

    // Count mode, period 0 acts as 1, with 16-bit wrap
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_FFFE);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'h7);
    expect_strobe(1, 16'hFFFE, "cnt0");
    expect_strobe(2, 16'hFFFF, "cnt1");
    expect_strobe(2, 16'h0000, "cnt2");
    expect_strobe(2, 16'h0001, "cnt3");

    // Blink mode, period 2, then disable mid-COUNT
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h0000_AAAA);
    wr(2'd2, 32'd2);
    wr(2'd0, 32'h5);
    expect_strobe(1, 16'hAAAA, "blk0");
    expect_strobe(3, 16'h0000, "blk1");
    expect_strobe(3, 16'hAAAA, "blk2");
    wr(2'd0, 32'h0);
    chk("dis_cs", {31'b0, m_chipselect}, 32'd0);
    idle_chk(6, "dis2");
    chk("dis_hold", m_writedata, 32'h0000_AAAA);
    rd_chk(2'd3, 32'hAAAA_0000, "dis_status");
    rd_chk(2'd0, 32'h0, "dis_ctrl");

    // FORCE is ignored while idle
    wr(2'd3, 32'h1);
    idle_chk(3, "force_idle");
    rd_chk(2'd3, 32'hAAAA_0000, "force_idle_status");

    // Count mode, long period: FORCE advances immediately
    wr(2'd1, 32'h0000_1234);
    wr(2'd2, 32'd1000);
    wr(2'd0, 32'h7);
    expect_strobe(1, 16'h1234, "lng0");
    rd_chk(2'd2, 32'h0000_03E8, "lng_period");
    idle_chk(3, "lng_wait");
    wr(2'd3, 32'h1);
    expect_strobe(1, 16'h1235, "force1");
    idle_chk(2, "force_wait");
    wr(2'd3, 32'h1);
    rd_chk(2'd3, 32'h1236_0001, "force2_status");
    @(posedge clk);
    #1;
    chk("force2_cs", {31'b0, m_chipselect}, 32'd1);
    chk("force2_data", m_writedata, 32'h0000_1236);

    // Asynchronous reset while the strobe is high
    reset_n = 1'b0;
    #1;
    chk("arst_cs", {31'b0, m_chipselect}, 32'd0);
    chk("arst_wn", {31'b0, m_write_n}, 32'd1);
    chk("arst_wd", m_writedata, 32'h0);
    for (int a = 0; a < 4; a++) rd_chk(a[1:0], 32'h0, "arst_rd");
    @(negedge clk);
    reset_n = 1'b1;
    idle_chk(4, "post_rst");
    rd_chk(2'd3, 32'h0, "post_rst_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nios_ledr_sequencer.md
# nios_ledr_sequencer

Autonomous LED pattern sequencer for the NIOS_core LED output path. An Avalon-MM slave holds its configuration: mode, pattern and step period. An Avalon-MM master side issues single-cycle writes into the 16-bit LED PIO (register 0) at a programmable rate. This frees the NIOS CPU from per-step LED updates. It sits between the system interconnect (slave side) and the LED PIO s1 port (master side).

## Interface
- No parameters. Data width is fixed at 16 LED bits, carried in 32-bit Avalon words.
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  2  slave register select
- chipselect  input  1  slave select
- write_n  input  1  slave write strobe, active low
- writedata  input  32  slave write data
- readdata  output  32  slave read data, combinational from address, zero wait states
- m_address  output  2  PIO register address, constant 0
- m_chipselect  output  1  PIO select, registered
- m_write_n  output  1  PIO write strobe, active low, registered
- m_writedata  output  32  PIO write data {16'b0, cur}, registered

## Operation
- Slave write condition: chipselect && ~write_n.
- Registers (all reset to 0):
  - addr0 CTRL: bit0 enable, bits2:1 mode. Mode values: 0 static, 1 rotate-left, 2 blink, 3 count-up.
  - addr1 PATTERN: [15:0].
  - addr2 PERIOD: [23:0].
  - addr3 STATUS/FORCE.
- Readback (unused bits read 0):
  - addr0 = {29'b0, mode, enable}
  - addr1 = {16'b0, PATTERN}
  - addr2 = {8'b0, PERIOD}
  - addr3 = {cur, 15'b0, running}
- Internal state: cur[15:0], phase (1 bit), cnt[23:0], FSM state.
- FSM states: IDLE, WRITE, COUNT. running = (state != IDLE).
- IDLE:
  - Master outputs inactive: chipselect 0, write_n 1.
  - A CTRL write with bit0=1 loads cur=PATTERN and phase=1, then goes to WRITE.
- WRITE (exactly 1 cycle):
  - Drives m_chipselect=1, m_write_n=0, m_writedata={16'b0, cur}.
  - Loads cnt = max(PERIOD,1)-1, then goes to COUNT.
- COUNT:
  - Decrements cnt each cycle.
  - When cnt==0: computes the next cur and goes to WRITE.
- Next-value rules:
  - static: cur = PATTERN. Sampling the current PATTERN lets live edits take effect.
  - rotate: cur = {cur[14:0], cur[15]}.
  - blink: phase toggles; cur = phase_new ? PATTERN : 16'h0000.
  - count: cur = cur + 1, mod 2^16. 16'hFFFF wraps to 16'h0000.
- CTRL write with bit0=1 while running: restart. Reload cur=PATTERN, phase=1, go to WRITE next cycle. This also applies a mode change.
- CTRL write with bit0=0: go to IDLE next cycle from any state; no further master writes. The PIO retains its last value.
- FORCE: write to addr3 with writedata bit0=1 while in COUNT behaves as cnt==0: advance cur and go to WRITE. Ignored in IDLE and WRITE.
- PERIOD write: takes effect at the next cnt reload. The current count is not disturbed.
- PATTERN write: no immediate master write. Used at the next restart, static step, or blink-on step.
- Reset mid-operation: all registers and cur/phase/cnt clear, state goes to IDLE, master outputs go inactive immediately (asynchronous).
- Master side assumes the PIO has zero wait states (no waitrequest). One strobe cycle equals one completed PIO write.

## Timing
- Reset values: readdata follows address with all registers 0; m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0.
- Enable latency: slave CTRL write sampled at edge t; master strobe is high in the cycle after edge t+1.
- Step interval: consecutive master strobes are exactly max(PERIOD,1)+1 cycles apart (1 WRITE + max(PERIOD,1) COUNT cycles).
- FORCE latency: the strobe appears one cycle after the FORCE write edge.
- Disable: no strobe occurs in any cycle after the edge that samples enable=0.
- m_writedata holds its last value between strobes. It is a don't-care while the strobe is inactive, but is required to be stable.

## Test plan
- Reset, then write PATTERN=16'h00F0, PERIOD=3, CTRL=0b001 (static) -> first strobe with data 0x000000F0 one cycle after enable; further strobes every 4 cycles; STATUS reads 0x00F00001.
- Rotate mode, PATTERN=16'h8001, PERIOD=1 -> strobes every 2 cycles with data 0x8001, 0x0003, 0x0006, 0x000C.
- Count mode, PATTERN=16'hFFFE, PERIOD=0 -> data sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001, strobes every 2 cycles (PERIOD 0 treated as 1).
- Blink mode, PATTERN=16'hAAAA, PERIOD=2 -> data alternates 0xAAAA, 0x0000, 0xAAAA at 3-cycle spacing. Write CTRL=0 mid-COUNT -> no further strobes; STATUS bit0=0.
- Count mode with PERIOD=1000: FORCE write -> strobe one cycle later with cur+1. Then assert reset_n=0 during WRITE -> m_chipselect drops immediately, all readbacks read 0.
